// File: rtl/led_frame_sequencer_if.sv
// Buffer-read and strip-driver stream bundle for the LED frame sequencer.
// master: sequencer side (drives address and the color stream); slave: buffer plus strip driver.
// Signals: led_addr/green_in/red_in/blue_in/color_valid_in (buffer), color_out/_valid/_ready (driver).
interface led_frame_sequencer_if #(
    parameter int LED_ADDRESS_WIDTH = 10
);
    logic [LED_ADDRESS_WIDTH-1:0] led_addr;
    logic [7:0]                   green_in;
    logic [7:0]                   red_in;
    logic [7:0]                   blue_in;
    logic                         color_valid_in;
    logic [23:0]                  color_out;
    logic                         color_out_valid;
    logic                         color_out_ready;

    modport master (
        output led_addr,
        output color_out,
        output color_out_valid,
        input  green_in,
        input  red_in,
        input  blue_in,
        input  color_valid_in,
        input  color_out_ready
    );

    modport slave (
        input  led_addr,
        input  color_out,
        input  color_out_valid,
        output green_in,
        output red_in,
        output blue_in,
        output color_valid_in,
        output color_out_ready
    );
endinterface

// File: rtl/led_frame_sequencer.sv
// Reads the LED color buffer once per frame and streams GRB words to the strip driver.
// Latency per LED with immediate valid/ready: SETTLE_CYCLES + 2 cycles; then a LATCH_CYCLES gap per frame.
// Backpressure: color_out/color_out_valid hold in PRESENT until color_out_ready; the frame stalls meanwhile.
// Ports: clk_led, rst (sync, active-high), enable, bus (led_frame_sequencer_if.master),
//        frame_done (1-cycle pulse), timeout_error (sticky), busy (not idle).
module led_frame_sequencer #(
    parameter int NUM_LEDS          = 50,
    parameter int LED_ADDRESS_WIDTH = 10,
    parameter int SETTLE_CYCLES     = 3,
    parameter int VALID_TIMEOUT     = 16,
    parameter int LATCH_CYCLES      = 8000
) (
    input  logic                         clk_led,
    input  logic                         rst,
    input  logic                         enable,
    led_frame_sequencer_if.master        bus,
    output logic                         frame_done,
    output logic                         timeout_error,
    output logic                         busy
);

    // Frame state machine encoding
    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] REQUEST    = 3'd1;
    localparam logic [2:0] WAIT_VALID = 3'd2;
    localparam logic [2:0] PRESENT    = 3'd3;
    localparam logic [2:0] LATCH      = 3'd4;

    // Each counter is sized to hold its own terminal count without overflow
    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int WAIT_W   = $clog2(VALID_TIMEOUT + 1);
    localparam int LATCH_W  = $clog2(LATCH_CYCLES + 1);

    localparam logic [SETTLE_W-1:0]          SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [WAIT_W-1:0]            WAIT_LAST   = WAIT_W'(VALID_TIMEOUT - 1);
    localparam logic [LATCH_W-1:0]           LATCH_LAST  = LATCH_W'(LATCH_CYCLES - 1);
    localparam logic [LED_ADDRESS_WIDTH-1:0] ADDR_LAST   = LED_ADDRESS_WIDTH'(NUM_LEDS - 1);

    logic [2:0]                   state;
    logic [LED_ADDRESS_WIDTH-1:0] addr;
    logic [23:0]                  color;
    logic                         color_vld;
    logic [SETTLE_W-1:0]          settle_cnt;
    logic [WAIT_W-1:0]            wait_cnt;
    logic [LATCH_W-1:0]           latch_cnt;
    logic                         xfer;

    assign xfer = color_vld & bus.color_out_ready;

    always_ff @(posedge clk_led) begin
        if (rst) begin
            state         <= IDLE;
            addr          <= '0;
            color         <= '0;
            color_vld     <= 1'b0;
            timeout_error <= 1'b0;
            settle_cnt    <= '0;
            wait_cnt      <= '0;
            latch_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    addr <= '0;
                    if (enable) begin
                        state      <= REQUEST;
                        settle_cnt <= '0;
                    end
                end

                // Address is held so the buffer output can settle; any
                // color_valid_in seen here may belong to the previous address.
                REQUEST: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state    <= WAIT_VALID;
                        wait_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end

                // A valid on the final wait cycle is tested first, so it
                // beats the timeout.
                WAIT_VALID: begin
                    if (bus.color_valid_in) begin
                        color     <= {bus.green_in, bus.red_in, bus.blue_in};
                        color_vld <= 1'b1;
                        state     <= PRESENT;
                    end else if (wait_cnt == WAIT_LAST) begin
                        color         <= 24'h000000;
                        color_vld     <= 1'b1;
                        timeout_error <= 1'b1;
                        state         <= PRESENT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                // color keeps its value after the transfer; only the valid drops.
                PRESENT: begin
                    if (xfer) begin
                        color_vld <= 1'b0;
                        if (addr == ADDR_LAST) begin
                            state     <= LATCH;
                            latch_cnt <= '0;
                        end else begin
                            addr       <= addr + 1'b1;
                            state      <= REQUEST;
                            settle_cnt <= '0;
                        end
                    end
                end

                // enable is only looked at when the gap ends, so a mid-frame
                // drop still lets the frame and its latch complete.
                LATCH: begin
                    if (latch_cnt == LATCH_LAST) begin
                        addr       <= '0;
                        settle_cnt <= '0;
                        state      <= enable ? REQUEST : IDLE;
                    end else begin
                        latch_cnt <= latch_cnt + 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    addr      <= '0;
                    color_vld <= 1'b0;
                end
            endcase
        end
    end

    assign bus.led_addr        = addr;
    assign bus.color_out       = color;
    assign bus.color_out_valid = color_vld;

    // Pulse on the last latch cycle; decoded so it is exactly one cycle wide.
    assign frame_done = (state == LATCH) && (latch_cnt == LATCH_LAST);
    assign busy       = (state != IDLE);

endmodule

// File: tb/tb_led_frame_sequencer.sv
module tb_led_frame_sequencer;

    localparam int N_LEDS = 4;
    localparam int AW     = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic ready = 1'b0;
    int   buf_mode = 0;          // 0: always valid, 1: never valid at bad_addr, 2: man_valid
    logic [AW-1:0] bad_addr = '0;
    logic man_valid = 1'b0;

    logic frame_done;
    logic timeout_error;
    logic busy;

    int errors = 0;
    int checks = 0;

    int cycle = 0;
    int xfer_cnt = 0;
    int fd_cnt = 0;
    int fd_cycle = 0;
    logic [23:0] xfer_q[$];
    int          xfer_cyc_q[$];

    led_frame_sequencer_if #(.LED_ADDRESS_WIDTH(AW)) bus ();

    led_frame_sequencer #(
        .NUM_LEDS(N_LEDS),
        .LED_ADDRESS_WIDTH(AW),
        .SETTLE_CYCLES(3),
        .VALID_TIMEOUT(8),
        .LATCH_CYCLES(10)
    ) dut (
        .clk_led(clk),
        .rst(rst),
        .enable(enable),
        .bus(bus),
        .frame_done(frame_done),
        .timeout_error(timeout_error),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Buffer model: addr-coded colors
    always_comb begin
        bus.green_in       = bus.led_addr[7:0];
        bus.red_in         = bus.led_addr[7:0] + 8'd16;
        bus.blue_in        = bus.led_addr[7:0] + 8'd32;
        bus.color_valid_in = 1'b1;
        case (buf_mode)
            1:       bus.color_valid_in = (bus.led_addr != bad_addr);
            2:       bus.color_valid_in = man_valid;
            default: bus.color_valid_in = 1'b1;
        endcase
    end

    assign bus.color_out_ready = ready;

    // Inputs change just after posedge, so negedge values are what the next edge sees
    always @(negedge clk) begin
        cycle <= cycle + 1;
        if (!rst && bus.color_out_valid && ready) begin
            xfer_q.push_back(bus.color_out);
            xfer_cyc_q.push_back(cycle);
            xfer_cnt <= xfer_cnt + 1;
        end
        if (frame_done) begin
            fd_cnt   <= fd_cnt + 1;
            fd_cycle <= cycle;
        end
    end

    function automatic logic [23:0] word(input int a);
        logic [7:0] g;
        g = 8'(a);
        return {g, g + 8'd16, g + 8'd32};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_log();
        xfer_q.delete();
        xfer_cyc_q.delete();
    endtask

    task automatic wait_idle(input string name);
        for (int n = 0; n < 300 && busy !== 1'b0; n++) sample();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle: busy=%b required 0 (timed out)", name, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        sample();
        checks++; if (bus.led_addr !== '0) begin errors++; $display("FAIL rst_addr: got %0d required 0", bus.led_addr); end
        checks++; if (bus.color_out !== 24'h0) begin errors++; $display("FAIL rst_color: got %h required 000000", bus.color_out); end
        checks++; if (bus.color_out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", bus.color_out_valid); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_frame_done: got %b required 0", frame_done); end
        checks++; if (timeout_error !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b required 0", timeout_error); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy); end
    endtask

    task automatic test_frame();
        int fd0;
        clear_log();
        fd0 = fd_cnt;
        tick();
        buf_mode = 0;
        enable = 1'b1;
        ready = 1'b1;
        for (int n = 0; n < 200 && fd_cnt == fd0; n++) sample();
        checks++; if (fd_cnt !== fd0 + 1) begin errors++; $display("FAIL frame_done_seen: got %0d pulses required 1", fd_cnt - fd0); end
        checks++; if (xfer_q.size() !== N_LEDS) begin errors++; $display("FAIL frame_count: got %0d transfers required %0d", xfer_q.size(), N_LEDS); end
        for (int i = 0; i < N_LEDS; i++) begin
            logic [23:0] got;
            got = (xfer_q.size() > i) ? xfer_q[i] : 24'hxxxxxx;
            checks++;
            if (got !== word(i)) begin errors++; $display("FAIL frame_word%0d: got %h required %h", i, got, word(i)); end
        end
        for (int i = 1; i < N_LEDS; i++) begin
            int gap;
            gap = (xfer_cyc_q.size() > i) ? xfer_cyc_q[i] - xfer_cyc_q[i-1] : -1;
            checks++;
            if (gap !== 5) begin errors++; $display("FAIL frame_spacing%0d: got %0d cycles required 5", i, gap); end
        end
        begin
            int lat;
            lat = (xfer_cyc_q.size() > 0) ? fd_cycle - xfer_cyc_q[$] : -1;
            checks++;
            if (lat !== 10) begin errors++; $display("FAIL frame_latch_gap: got %0d cycles required 10", lat); end
        end
        sample();
        checks++; if (bus.led_addr !== '0) begin errors++; $display("FAIL frame_restart_addr: got %0d required 0", bus.led_addr); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL frame_restart_busy: got %b required 1", busy); end
        checks++; if (fd_cnt !== fd0 + 1) begin errors++; $display("FAIL frame_done_width: got %0d pulses required 1", fd_cnt - fd0); end
        tick();
        enable = 1'b0;
        wait_idle("frame");
    endtask

    task automatic test_backpressure();
        int snap;
        int hold_bad;
        int hits;
        clear_log();
        tick();
        buf_mode = 0;
        ready = 1'b1;
        enable = 1'b1;
        for (int n = 0; n < 100 && xfer_q.size() < 2; n++) sample();
        tick();
        ready = 1'b0;
        for (int n = 0; n < 50 && bus.color_out_valid !== 1'b1; n++) sample();
        checks++; if (bus.color_out !== word(2)) begin errors++; $display("FAIL bp_word: got %h required %h", bus.color_out, word(2)); end
        checks++; if (bus.led_addr !== AW'(2)) begin errors++; $display("FAIL bp_addr: got %0d required 2", bus.led_addr); end
        snap = xfer_q.size();
        hold_bad = 0;
        for (int n = 0; n < 20; n++) begin
            sample();
            if (bus.color_out_valid !== 1'b1 || bus.color_out !== word(2) || bus.led_addr !== AW'(2)) hold_bad++;
        end
        checks++; if (hold_bad !== 0) begin errors++; $display("FAIL bp_hold: got %0d unstable cycles required 0", hold_bad); end
        checks++; if (xfer_q.size() !== snap) begin errors++; $display("FAIL bp_no_xfer: got %0d transfers required %0d", xfer_q.size(), snap); end
        tick();
        ready = 1'b1;
        sample();
        checks++; if (xfer_q.size() !== snap + 1) begin errors++; $display("FAIL bp_release: got %0d transfers required %0d", xfer_q.size(), snap + 1); end
        sample();
        checks++; if (bus.color_out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop: got %b required 0", bus.color_out_valid); end
        tick();
        enable = 1'b0;
        wait_idle("bp");
        hits = 0;
        foreach (xfer_q[i]) if (xfer_q[i] === word(2)) hits++;
        checks++; if (xfer_q.size() !== N_LEDS) begin errors++; $display("FAIL bp_count: got %0d transfers required %0d", xfer_q.size(), N_LEDS); end
        checks++; if (hits !== 1) begin errors++; $display("FAIL bp_single: got %0d transfers of addr2 required 1", hits); end
    endtask

    task automatic test_timeout();
        int gap;
        clear_log();
        tick();
        buf_mode = 1;
        bad_addr = AW'(1);
        ready = 1'b1;
        enable = 1'b1;
        for (int n = 0; n < 100 && xfer_q.size() < 1; n++) sample();
        checks++; if (timeout_error !== 1'b0) begin errors++; $display("FAIL to_early: got %b required 0", timeout_error); end
        for (int n = 0; n < 100 && xfer_q.size() < 2; n++) sample();
        checks++; if (xfer_q.size() < 2 || xfer_q[1] !== 24'h000000) begin errors++; $display("FAIL to_black: got %h required 000000", (xfer_q.size() > 1) ? xfer_q[1] : 24'hxxxxxx); end
        gap = (xfer_cyc_q.size() > 1) ? xfer_cyc_q[1] - xfer_cyc_q[0] : -1;
        checks++; if (gap !== 12) begin errors++; $display("FAIL to_wait_len: got %0d cycles required 12", gap); end
        checks++; if (timeout_error !== 1'b1) begin errors++; $display("FAIL to_flag: got %b required 1", timeout_error); end
        tick();
        enable = 1'b0;
        buf_mode = 0;
        wait_idle("to_frame1");
        // Second, clean frame: flag must persist
        clear_log();
        tick();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        wait_idle("to_frame2");
        checks++; if (xfer_q.size() < 2 || xfer_q[1] !== word(1)) begin errors++; $display("FAIL to_frame2_word: got %h required %h", (xfer_q.size() > 1) ? xfer_q[1] : 24'hxxxxxx, word(1)); end
        checks++; if (timeout_error !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b required 1", timeout_error); end
    endtask

    task automatic test_enable_drop();
        int fd0;
        clear_log();
        fd0 = fd_cnt;
        tick();
        buf_mode = 0;
        ready = 1'b1;
        enable = 1'b1;
        for (int n = 0; n < 100 && bus.led_addr !== AW'(1); n++) sample();
        tick();
        enable = 1'b0;
        wait_idle("en");
        checks++; if (xfer_q.size() !== N_LEDS) begin errors++; $display("FAIL en_count: got %0d transfers required %0d", xfer_q.size(), N_LEDS); end
        checks++; if (xfer_q.size() < 4 || xfer_q[2] !== word(2) || xfer_q[3] !== word(3)) begin errors++; $display("FAIL en_tail: addr2/3 words not delivered as required %h %h", word(2), word(3)); end
        checks++; if (fd_cnt !== fd0 + 1) begin errors++; $display("FAIL en_frame_done: got %0d pulses required 1", fd_cnt - fd0); end
        checks++; if (bus.led_addr !== '0) begin errors++; $display("FAIL en_addr: got %0d required 0", bus.led_addr); end
        for (int n = 0; n < 5; n++) sample();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_stays_idle: busy=%b required 0", busy); end
    endtask

    task automatic test_reset_mid();
        int snap;
        clear_log();
        tick();
        buf_mode = 0;
        ready = 1'b0;
        enable = 1'b1;
        for (int n = 0; n < 50 && bus.color_out_valid !== 1'b1; n++) sample();
        checks++; if (bus.color_out !== word(0)) begin errors++; $display("FAIL rm_present: got %h required %h", bus.color_out, word(0)); end
        snap = xfer_cnt;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sample();
        checks++; if (bus.color_out_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b required 0", bus.color_out_valid); end
        checks++; if (bus.color_out !== 24'h0) begin errors++; $display("FAIL rm_color: got %h required 000000", bus.color_out); end
        checks++; if (timeout_error !== 1'b0) begin errors++; $display("FAIL rm_timeout: got %b required 0", timeout_error); end
        checks++; if (busy !== 1'b0 || bus.led_addr !== '0 || frame_done !== 1'b0) begin errors++; $display("FAIL rm_state: busy=%b addr=%0d frame_done=%b required 0/0/0", busy, bus.led_addr, frame_done); end
        checks++; if (xfer_cnt !== snap) begin errors++; $display("FAIL rm_no_xfer: got %0d transfers required %0d", xfer_cnt, snap); end
        tick();
        ready = 1'b1;
        for (int n = 0; n < 100 && xfer_q.size() < 1; n++) sample();
        checks++; if (xfer_q.size() < 1 || xfer_q[0] !== word(0)) begin errors++; $display("FAIL rm_restart: got %h required %h", (xfer_q.size() > 0) ? xfer_q[0] : 24'hxxxxxx, word(0)); end
        tick();
        enable = 1'b0;
        wait_idle("rm");
    endtask

    task automatic test_valid_in_request();
        tick();
        buf_mode = 2;
        man_valid = 1'b1;
        ready = 1'b0;
        enable = 1'b1;
        for (int n = 0; n < 4; n++) tick();   // IDLE edge + three REQUEST edges
        man_valid = 1'b0;
        for (int n = 0; n < 7; n++) tick();   // seven of eight WAIT cycles
        sample();
        checks++; if (bus.color_out_valid !== 1'b0) begin errors++; $display("FAIL vr_premature: valid=%b required 0", bus.color_out_valid); end
        checks++; if (timeout_error !== 1'b0) begin errors++; $display("FAIL vr_flag_early: got %b required 0", timeout_error); end
        tick();
        sample();
        checks++; if (bus.color_out_valid !== 1'b1) begin errors++; $display("FAIL vr_timeout_valid: got %b required 1", bus.color_out_valid); end
        checks++; if (bus.color_out !== 24'h000000) begin errors++; $display("FAIL vr_black: got %h required 000000", bus.color_out); end
        checks++; if (timeout_error !== 1'b1) begin errors++; $display("FAIL vr_flag: got %b required 1", timeout_error); end
        tick();
        buf_mode = 0;
        ready = 1'b1;
        enable = 1'b0;
        wait_idle("vr");
    endtask

    initial begin
        test_reset();
        test_frame();
        test_backpressure();
        test_timeout();
        test_enable_drop();
        test_reset_mid();
        test_valid_in_request();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
